data_sync_mc: RTL

Multi-channel, parametrised successor to the single-bus data synchronizer. It sits on the destination clock domain and brings NUM_CHANNELS independent (bus, enable) pairs across a clock boundary. Each channel synchronises its enable through a NUM_STAGES flop chain and captures the bus on the detected event. It then holds the word under a valid/ready handshake, returns an acknowledge toggle for the source-side handshake, and flags overruns.

---
 rtl/data_sync_mc_if.sv | 37 +++
 rtl/data_sync_mc.sv | 104 ++++++++++
 2 files changed

// File: rtl/data_sync_mc_if.sv
// Channel bundle for data_sync_mc: source/consumer side (master) and synchroniser side (slave).
// With DSYNC_OVR_CNT_EN defined the bundle also carries the per-channel overrun counters.
interface data_sync_mc_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int BUS_WIDTH    = 8
);
    logic [NUM_CHANNELS*BUS_WIDTH-1:0] unsync_bus;
    logic [NUM_CHANNELS-1:0]           bus_enable;
    logic [NUM_CHANNELS-1:0]           sync_ready;
    logic                              overrun_clr;
    logic [NUM_CHANNELS*BUS_WIDTH-1:0] sync_bus;
    logic [NUM_CHANNELS-1:0]           enable_pulse;
    logic [NUM_CHANNELS-1:0]           sync_valid;
    logic [NUM_CHANNELS-1:0]           ack_toggle;
    logic [NUM_CHANNELS-1:0]           overrun;
`ifdef DSYNC_OVR_CNT_EN
    logic [NUM_CHANNELS*8-1:0]         ovr_count;

    modport master (
        output unsync_bus, bus_enable, sync_ready, overrun_clr,
        input  sync_bus, enable_pulse, sync_valid, ack_toggle, overrun, ovr_count
    );
    modport slave (
        input  unsync_bus, bus_enable, sync_ready, overrun_clr,
        output sync_bus, enable_pulse, sync_valid, ack_toggle, overrun, ovr_count
    );
`else
    modport master (
        output unsync_bus, bus_enable, sync_ready, overrun_clr,
        input  sync_bus, enable_pulse, sync_valid, ack_toggle, overrun
    );
    modport slave (
        input  unsync_bus, bus_enable, sync_ready, overrun_clr,
        output sync_bus, enable_pulse, sync_valid, ack_toggle, overrun
    );
`endif
endinterface

// File: rtl/data_sync_mc.sv
// Multi-channel enable synchroniser with bus capture, valid/ready hold, ack toggle and sticky overrun (optional DSYNC_OVR_CNT_EN counters).
// Latency: enable change sampled at edge E0 -> capture, pulse and ack flip at edge E(NUM_STAGES).
// Backpressure: sync_ready low keeps the word held; a new capture replaces it and flags overrun.
module data_sync_mc #(
    parameter int NUM_STAGES   = 2,
    parameter int BUS_WIDTH    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int TOGGLE_MODE  = 0
) (
    input  logic          CLK,
    input  logic          RST,
    data_sync_mc_if.slave dsif
);

    logic [NUM_CHANNELS-1:0][NUM_STAGES-1:0] sync_q;
    logic [NUM_CHANNELS-1:0]                 prev_q;
    logic [NUM_CHANNELS-1:0][BUS_WIDTH-1:0]  data_q;
    logic [NUM_CHANNELS-1:0]                 pulse_q;
    logic [NUM_CHANNELS-1:0]                 valid_q;
    logic [NUM_CHANNELS-1:0]                 ack_q;
    logic [NUM_CHANNELS-1:0]                 ovr_q;

    logic [NUM_CHANNELS-1:0]                 last;
    logic [NUM_CHANNELS-1:0]                 evt;
    logic [NUM_CHANNELS-1:0]                 ovr_set;

    always_comb begin
        last    = '0;
        evt     = '0;
        ovr_set = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            last[c]    = sync_q[c][NUM_STAGES-1];
            evt[c]     = (TOGGLE_MODE != 0) ? (last[c] ^ prev_q[c]) : (last[c] & ~prev_q[c]);
            // an unconsumed word is about to be overwritten
            ovr_set[c] = evt[c] & valid_q[c] & ~dsif.sync_ready[c];
        end
    end

    // prev_q resets to 0 so a level enable already high at release yields one event
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                sync_q[c] <= {sync_q[c][NUM_STAGES-2:0], dsif.bus_enable[c]};
                prev_q[c] <= sync_q[c][NUM_STAGES-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q  <= '0;
            pulse_q <= '0;
            valid_q <= '0;
            ack_q   <= '0;
            ovr_q   <= '0;
        end else begin
            pulse_q <= evt;
            ovr_q   <= (dsif.overrun_clr ? '0 : ovr_q) | ovr_set;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (evt[c]) begin
                    data_q[c]  <= dsif.unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
                    valid_q[c] <= 1'b1;
                    ack_q[c]   <= ~ack_q[c];
                end else if (dsif.sync_ready[c]) begin
                    valid_q[c] <= 1'b0;
                end
            end
        end
    end

    assign dsif.sync_bus     = data_q;
    assign dsif.enable_pulse = pulse_q;
    assign dsif.sync_valid   = valid_q;
    assign dsif.ack_toggle   = ack_q;
    assign dsif.overrun      = ovr_q;

`ifdef DSYNC_OVR_CNT_EN
    logic [NUM_CHANNELS-1:0][7:0] cnt_q;

    // an increment on the clear edge restarts the count at 1
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (ovr_set[c]) begin
                    if (dsif.overrun_clr)
                        cnt_q[c] <= 8'd1;
                    else if (cnt_q[c] != 8'hFF)
                        cnt_q[c] <= cnt_q[c] + 8'd1;
                end else if (dsif.overrun_clr) begin
                    cnt_q[c] <= 8'd0;
                end
            end
        end
    end

    assign dsif.ovr_count = cnt_q;
`endif

endmodule
